fifo_rd_drain: RTL and testbench

Read-side drain stage on the consumer side of the FIFO control unit. It issues pops to the FIFO only when a word is available and local space is guaranteed, absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer, and presents words on a valid/ready stream. It also keeps a drained-word counter and a sticky error flag for FIFO read errors.

---
 rtl/fifo_rd_drain.sv | 116 +++++++++++
 tb/tb_fifo_rd_drain.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: consumer-side drain stage for the FIFO read port.
// Pops the FIFO only when local space is guaranteed, absorbs the one-cycle
// read latency in a 2-entry skid buffer and emits words on valid/ready.
// Ports:
//   clk_i, rst_i             clock, async active-high reset
//   enable_i                 allow new pops (buffered words drain regardless)
//   clr_i                    sync clear of pop_count_o and err_o
//   fifo_empty_i             FIFO empty flag
//   fifo_rdata_i             FIFO read data, valid the cycle after a pop
//   fifo_rd_error_i          FIFO read-error flag
//   fifo_rd_en_o             pop request to the FIFO
//   m_valid_o/m_ready_i      output handshake
//   m_data_o                 output word (buffer head)
//   occupancy_o              words held in the skid buffer (0..2)
//   pop_count_o              words accepted downstream since reset/clear
//   err_o                    sticky read-error flag
module fifo_rd_drain #(
    parameter int WIDTH     = 1024,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 clr_i,
    input  logic                 fifo_empty_i,
    input  logic [WIDTH-1:0]     fifo_rdata_i,
    input  logic                 fifo_rd_error_i,
    output logic                 fifo_rd_en_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [WIDTH-1:0]     m_data_o,
    output logic [1:0]           occupancy_o,
    output logic [CNT_WIDTH-1:0] pop_count_o,
    output logic                 err_o
);

    logic [WIDTH-1:0]     buf_q [2];
    logic [WIDTH-1:0]     buf_d [2];
    logic                 head_q, head_d;
    logic                 tail_q, tail_d;
    logic [1:0]           occ_q, occ_d;
    logic                 inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic                 hs;
    logic                 cap;
    logic [1:0]           committed;
    logic [1:0]           room_used;

    always_comb begin
        m_valid_o = (occ_q != 2'd0);
        m_data_o  = buf_q[head_q];
        hs        = m_valid_o & m_ready_i;
        cap       = inflight_q;

        // Words already owned (buffered + inflight) never exceed 2, and hs
        // implies occ >= 1, so the subtraction cannot underflow.
        committed = occ_q + {1'b0, inflight_q};
        room_used = committed - {1'b0, hs};

        // Gated by reset so the FIFO never loses a word while we are held.
        fifo_rd_en_o = ~rst_i & enable_i & ~fifo_empty_i
                     & (room_used < 2'd2);

        inflight_d = fifo_rd_en_o;

        buf_d = buf_q;
        if (cap) begin
            buf_d[tail_q] = fifo_rdata_i;
        end
        head_d = head_q ^ hs;
        tail_d = tail_q ^ cap;

        unique case ({cap, hs})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        if (clr_i) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, hs};
            err_d = err_q | fifo_rd_error_i;
        end

        occupancy_o = occ_q;
        pop_count_o = cnt_q;
        err_o       = err_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: directed bench for fifo_rd_drain with a FIFO read model.
// Inputs change on the falling edge; outputs are sampled before the rising edge.
module tb_fifo_rd_drain;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          enable_i;
    logic          clr_i;
    logic          fifo_empty_i;
    logic [W-1:0]  fifo_rdata_i;
    logic          fifo_rd_error_i;
    logic          fifo_rd_en_o;
    logic          m_valid_o;
    logic          m_ready_i;
    logic [W-1:0]  m_data_o;
    logic [1:0]    occupancy_o;
    logic [CW-1:0] pop_count_o;
    logic          err_o;

    fifo_rd_drain #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .enable_i        (enable_i),
        .clr_i           (clr_i),
        .fifo_empty_i    (fifo_empty_i),
        .fifo_rdata_i    (fifo_rdata_i),
        .fifo_rd_error_i (fifo_rd_error_i),
        .fifo_rd_en_o    (fifo_rd_en_o),
        .m_valid_o       (m_valid_o),
        .m_ready_i       (m_ready_i),
        .m_data_o        (m_data_o),
        .occupancy_o     (occupancy_o),
        .pop_count_o     (pop_count_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] fq [$];
    logic [W-1:0] got [$];
    int           hs_cyc [$];
    int           cnum = 0;
    int           npop;
    int           first_pop;
    int           first_val;
    int           bp_viol;

    task automatic clr_track();
        got.delete();
        hs_cyc.delete();
        npop      = 0;
        first_pop = -1;
        first_val = -1;
        bp_viol   = 0;
    endtask

    task automatic push(input logic [W-1:0] v);
        fq.push_back(v);
        fifo_empty_i = 1'b0;
    endtask

    // One clock: sample outputs, let the edge happen, then model the FIFO.
    task automatic cyc();
        logic p;
        #1;
        p = fifo_rd_en_o;
        if (p) npop++;
        if (p && first_pop < 0) first_pop = cnum;
        if (m_valid_o && first_val < 0) first_val = cnum;
        if (occupancy_o > 2'd2) bp_viol++;
        if (occupancy_o == 2'd2 && fifo_rd_en_o && !m_ready_i) bp_viol++;
        if (m_valid_o && m_ready_i) begin
            got.push_back(m_data_o);
            hs_cyc.push_back(cnum);
        end
        @(posedge clk);
        #1;
        if (p && fq.size() > 0) fifo_rdata_i = fq.pop_front();
        else fifo_rdata_i = 16'hDEAD;
        fifo_empty_i = (fq.size() == 0);
        cnum++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        enable_i = 1'b0;
        clr_i = 1'b0;
        fifo_empty_i = 1'b1;
        fifo_rdata_i = '0;
        fifo_rd_error_i = 1'b0;
        m_ready_i = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (fifo_rd_en_o !== 1'b0) begin
            bad++; $display("FAIL rst_rd_en got=%0h exp=0", fifo_rd_en_o);
        end
        total++;
        if (m_valid_o !== 1'b0) begin
            bad++; $display("FAIL rst_valid got=%0h exp=0", m_valid_o);
        end
        total++;
        if (m_data_o !== '0) begin
            bad++; $display("FAIL rst_data got=%0h exp=0", m_data_o);
        end
        total++;
        if (occupancy_o !== 2'd0) begin
            bad++; $display("FAIL rst_occ got=%0h exp=0", occupancy_o);
        end
        total++;
        if (pop_count_o !== '0) begin
            bad++; $display("FAIL rst_cnt got=%0h exp=0", pop_count_o);
        end
        total++;
        if (err_o !== 1'b0) begin
            bad++; $display("FAIL rst_err got=%0h exp=0", err_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        clr_track();
        cyc();
        total++;
        if (m_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
            bad++;
            $display("FAIL post_rst_idle got=%0h/%0h exp=0/0",
                     m_valid_o, occupancy_o);
        end
    endtask

    task automatic test_stream();
        clr_track();
        for (int i = 0; i < 8; i++) push(16'h00A0 + 16'(i));
        enable_i = 1'b1;
        m_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        total++;
        if (first_val - first_pop !== 2) begin
            bad++;
            $display("FAIL stream_latency got=%0d exp=2",
                     first_val - first_pop);
        end
        total++;
        if (got.size() !== 8) begin
            bad++; $display("FAIL stream_count got=%0d exp=8", got.size());
        end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            total++;
            if (got[i] !== 16'h00A0 + 16'(i)) begin
                bad++;
                $display("FAIL stream_word%0d got=%0h exp=%0h",
                         i, got[i], 16'h00A0 + 16'(i));
            end
        end
        if (hs_cyc.size() == 8) begin
            total++;
            if (hs_cyc[7] - hs_cyc[0] !== 7) begin
                bad++;
                $display("FAIL stream_tput got=%0d exp=7",
                         hs_cyc[7] - hs_cyc[0]);
            end
        end
        total++;
        if (pop_count_o !== 4'd8) begin
            bad++; $display("FAIL stream_popcnt got=%0d exp=8", pop_count_o);
        end
        total++;
        if (err_o !== 1'b0) begin
            bad++; $display("FAIL stream_err got=%0h exp=0", err_o);
        end
    endtask

    task automatic test_backpressure();
        clr_track();
        m_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push(16'h00B0 + 16'(i));
        for (int i = 0; i < 10; i++) cyc();
        #1;
        total++;
        if (occupancy_o !== 2'd2) begin
            bad++; $display("FAIL bp_occ got=%0d exp=2", occupancy_o);
        end
        total++;
        if (m_valid_o !== 1'b1 || m_data_o !== 16'h00B0) begin
            bad++;
            $display("FAIL bp_head got=%0h/%0h exp=1/b0", m_valid_o, m_data_o);
        end
        total++;
        if (bp_viol !== 0 || npop !== 2) begin
            bad++;
            $display("FAIL bp_pops got=%0d/%0d exp=0/2", bp_viol, npop);
        end
        m_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        total++;
        if (got.size() !== 4 || npop !== 4) begin
            bad++;
            $display("FAIL bp_drain got=%0d/%0d exp=4/4", got.size(), npop);
        end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            total++;
            if (got[i] !== 16'h00B0 + 16'(i)) begin
                bad++;
                $display("FAIL bp_word%0d got=%0h exp=%0h",
                         i, got[i], 16'h00B0 + 16'(i));
            end
        end
    endtask

    task automatic test_empty();
        clr_track();
        enable_i = 1'b1;
        m_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        total++;
        if (npop !== 0 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL empty_nopop got=%0d/%0h exp=0/0", npop, err_o);
        end
        push(16'h00C5);
        for (int i = 0; i < 10; i++) cyc();
        total++;
        if (npop !== 1 || got.size() !== 1) begin
            bad++;
            $display("FAIL empty_one got=%0d/%0d exp=1/1", npop, got.size());
        end else begin
            total++;
            if (got[0] !== 16'h00C5) begin
                bad++; $display("FAIL empty_word got=%0h exp=c5", got[0]);
            end
        end
    endtask

    task automatic test_enable_drop();
        clr_track();
        m_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) push(16'h00D0 + 16'(i));
        enable_i = 1'b1;
        cyc();
        enable_i = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        total++;
        if (npop !== 1 || fq.size() !== 2) begin
            bad++;
            $display("FAIL endrop_pops got=%0d/%0d exp=1/2", npop, fq.size());
        end
        total++;
        if (got.size() !== 1) begin
            bad++; $display("FAIL endrop_cnt got=%0d exp=1", got.size());
        end else begin
            total++;
            if (got[0] !== 16'h00D0) begin
                bad++; $display("FAIL endrop_word got=%0h exp=d0", got[0]);
            end
        end
        fq.delete();
        fifo_empty_i = 1'b1;
    endtask

    task automatic test_err_clr();
        int n;
        bit seen;
        clr_track();
        enable_i = 1'b0;
        fifo_rd_error_i = 1'b1;
        cyc();
        fifo_rd_error_i = 1'b0;
        total++;
        if (err_o !== 1'b1) begin
            bad++; $display("FAIL err_set got=%0h exp=1", err_o);
        end
        for (int i = 0; i < 3; i++) cyc();
        total++;
        if (err_o !== 1'b1) begin
            bad++; $display("FAIL err_hold got=%0h exp=1", err_o);
        end
        m_ready_i = 1'b0;
        enable_i = 1'b1;
        push(16'h00F1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cyc();
            if (m_valid_o) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL clr_wait_valid got=0 exp=1");
        end
        total++;
        if (pop_count_o !== 4'd14) begin
            bad++; $display("FAIL clr_precnt got=%0d exp=14", pop_count_o);
        end
        n = got.size();
        m_ready_i = 1'b1;
        clr_i = 1'b1;
        cyc();
        clr_i = 1'b0;
        total++;
        if (pop_count_o !== '0 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL clr_hs got=%0d/%0h exp=0/0", pop_count_o, err_o);
        end
        total++;
        if (got.size() !== n + 1) begin
            bad++; $display("FAIL clr_word got=%0d exp=%0d", got.size(), n + 1);
        end
        enable_i = 1'b0;
    endtask

    task automatic test_wrap();
        clr_track();
        m_ready_i = 1'b1;
        enable_i = 1'b1;
        for (int i = 0; i < 17; i++) push(16'h0100 + 16'(i));
        for (int i = 0; i < 40 && got.size() < 17; i++) cyc();
        total++;
        if (got.size() !== 17) begin
            bad++; $display("FAIL wrap_cnt got=%0d exp=17", got.size());
        end
        total++;
        if (pop_count_o !== 4'd1) begin
            bad++; $display("FAIL wrap_popcnt got=%0d exp=1", pop_count_o);
        end
        for (int i = 0; i < got.size() && i < 17; i++) begin
            total++;
            if (got[i] !== 16'h0100 + 16'(i)) begin
                bad++;
                $display("FAIL wrap_word%0d got=%0h exp=%0h",
                         i, got[i], 16'h0100 + 16'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        clr_track();
        m_ready_i = 1'b0;
        enable_i = 1'b1;
        for (int i = 0; i < 4; i++) push(16'h00E0 + 16'(i));
        for (int i = 0; i < 5; i++) cyc();
        #1;
        total++;
        if (occupancy_o !== 2'd2) begin
            bad++; $display("FAIL rmid_occ got=%0d exp=2", occupancy_o);
        end
        rst_i = 1'b1;
        #1;
        total++;
        if (fifo_rd_en_o !== 1'b0 || m_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL rmid_ctl got=%0h/%0h exp=0/0",
                     fifo_rd_en_o, m_valid_o);
        end
        total++;
        if (m_data_o !== '0 || occupancy_o !== 2'd0) begin
            bad++;
            $display("FAIL rmid_buf got=%0h/%0h exp=0/0",
                     m_data_o, occupancy_o);
        end
        total++;
        if (pop_count_o !== '0 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL rmid_cnt got=%0h/%0h exp=0/0", pop_count_o, err_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        m_ready_i = 1'b1;
        clr_track();
        for (int i = 0; i < 10; i++) cyc();
        total++;
        if (got.size() !== 2 || npop !== 2) begin
            bad++;
            $display("FAIL rmid_after got=%0d/%0d exp=2/2", got.size(), npop);
        end else begin
            total++;
            if (got[0] !== 16'h00E2 || got[1] !== 16'h00E3) begin
                bad++;
                $display("FAIL rmid_words got=%0h,%0h exp=e2,e3",
                         got[0], got[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_empty();
        test_enable_drop();
        test_err_clr();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
